// File: rtl/spi_flash_read_cache_if.sv
// Bus bundle between the CPU load path, the flash read cache and the
// memory-mapped SPI flash word reader.
// slave  : the cache itself (serves CPU requests, drives flash strobes).
// master : the surroundings (CPU requester and flash reader).
interface spi_flash_read_cache_if;
    logic        cpu_rstrb;
    logic [19:0] cpu_word_address;
    logic [31:0] cpu_rdata;
    logic        cpu_rbusy;
    logic        flush;
    logic        flash_rstrb;
    logic [19:0] flash_word_address;
    logic [31:0] flash_rdata;
    logic        flash_rbusy;

    modport slave (
        input  cpu_rstrb, cpu_word_address, flush, flash_rdata, flash_rbusy,
        output cpu_rdata, cpu_rbusy, flash_rstrb, flash_word_address
    );

    modport master (
        output cpu_rstrb, cpu_word_address, flush, flash_rdata, flash_rbusy,
        input  cpu_rdata, cpu_rbusy, flash_rstrb, flash_word_address
    );
endinterface

// File: rtl/spi_flash_read_cache.sv
// Direct-mapped one-word-per-line read cache in front of the SPI flash word
// reader. Hits return in one cycle; misses issue a single-word flash read,
// re-strobing if the reader does not go busy within ACK_TIMEOUT cycles.
// Optional next-line prefetch after each demand fill: SPI_FLASH_PREFETCH_EN.
module spi_flash_read_cache #(
    parameter int LINES       = 16,
    parameter int ACK_TIMEOUT = 8
) (
    input logic                   clk,
    input logic                   reset,
    spi_flash_read_cache_if.slave bus
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 20 - IDX_W;
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, ISSUE, WAIT_ACK, WAIT_DATA, FILL
`ifdef SPI_FLASH_PREFETCH_EN
        , PF_ISSUE, PF_WAIT_ACK, PF_WAIT_DATA, PF_FILL
`endif
    } state_t;

    state_t state_reg, state_next;

    // Tag/data storage is deliberately left unreset; valid bits gate it.
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];
    logic [LINES-1:0] valid_reg;

    logic [19:0]      fetch_addr_reg;   // address of the fetch in flight
    logic [CNT_W-1:0] cnt_reg;          // cycles spent waiting for ack
    logic             flush_seen_reg;   // flush hit the current fetch
    logic             cpu_rbusy_reg;
    logic [31:0]      cpu_rdata_reg;

    logic             req_valid;
    logic [19:0]      req_addr;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             req_hit;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             fill_we;
    logic             cnt_done;
    logic             in_issue;
    logic             in_wait_ack;
    logic             in_wait_data;
    logic             in_fill;

`ifdef SPI_FLASH_PREFETCH_EN
    logic             pend_valid_reg;   // CPU request captured during prefetch
    logic [19:0]      pend_addr_reg;
    logic             in_prefetch;
    logic [19:0]      pf_addr;
    logic [IDX_W-1:0] pf_idx;
    logic [TAG_W-1:0] pf_tag;
    logic             pf_present;

    // A request parked during prefetch takes precedence over the CPU port.
    assign req_valid = pend_valid_reg | bus.cpu_rstrb;
    assign req_addr  = pend_valid_reg ? pend_addr_reg : bus.cpu_word_address;

    assign in_issue     = (state_reg == ISSUE)     || (state_reg == PF_ISSUE);
    assign in_wait_ack  = (state_reg == WAIT_ACK)  || (state_reg == PF_WAIT_ACK);
    assign in_wait_data = (state_reg == WAIT_DATA) || (state_reg == PF_WAIT_DATA);
    assign in_fill      = (state_reg == FILL)      || (state_reg == PF_FILL);
    assign in_prefetch  = (state_reg == PF_ISSUE) || (state_reg == PF_WAIT_ACK) ||
                          (state_reg == PF_WAIT_DATA) || (state_reg == PF_FILL);

    // Next line, wrapping at the top of the 20-bit word space.
    assign pf_addr    = fetch_addr_reg + 20'd1;
    assign pf_idx     = pf_addr[IDX_W-1:0];
    assign pf_tag     = pf_addr[19:IDX_W];
    assign pf_present = valid_reg[pf_idx] && (tag_mem[pf_idx] == pf_tag);
`else
    assign req_valid = bus.cpu_rstrb;
    assign req_addr  = bus.cpu_word_address;

    assign in_issue     = (state_reg == ISSUE);
    assign in_wait_ack  = (state_reg == WAIT_ACK);
    assign in_wait_data = (state_reg == WAIT_DATA);
    assign in_fill      = (state_reg == FILL);
`endif

    assign req_idx  = req_addr[IDX_W-1:0];
    assign req_tag  = req_addr[19:IDX_W];
    // A flush in the same cycle wins, so the request becomes a miss.
    assign req_hit  = req_valid && valid_reg[req_idx] &&
                      (tag_mem[req_idx] == req_tag) && !bus.flush;
    assign fill_idx = fetch_addr_reg[IDX_W-1:0];
    assign fill_tag = fetch_addr_reg[19:IDX_W];
    assign fill_we  = in_fill && !flush_seen_reg && !bus.flush;
    assign cnt_done = (cnt_reg == CNT_W'(ACK_TIMEOUT - 1));

    assign bus.flash_word_address = fetch_addr_reg;
    assign bus.cpu_rdata          = cpu_rdata_reg;
    assign bus.cpu_rbusy          = cpu_rbusy_reg;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state decode and the one-cycle flash strobe.
    always_comb begin
        state_next      = state_reg;
        bus.flash_rstrb = in_issue;
        case (state_reg)
            IDLE:      if (req_valid && !req_hit) state_next = ISSUE;
            ISSUE:     state_next = WAIT_ACK;
            WAIT_ACK:  if (bus.flash_rbusy) state_next = WAIT_DATA;
                       else if (cnt_done)   state_next = ISSUE;
            WAIT_DATA: if (!bus.flash_rbusy) state_next = FILL;
`ifdef SPI_FLASH_PREFETCH_EN
            FILL:         state_next = pf_present ? IDLE : PF_ISSUE;
            PF_ISSUE:     state_next = PF_WAIT_ACK;
            PF_WAIT_ACK:  if (bus.flash_rbusy) state_next = PF_WAIT_DATA;
                          else if (cnt_done)   state_next = PF_ISSUE;
            PF_WAIT_DATA: if (!bus.flash_rbusy) state_next = PF_FILL;
            PF_FILL:      state_next = IDLE;
`else
            FILL:      state_next = IDLE;
`endif
            default:   state_next = IDLE;
        endcase
    end

    // Request bookkeeping, ack timeout counter and CPU-facing outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_addr_reg <= '0;
            cnt_reg        <= '0;
            flush_seen_reg <= 1'b0;
            cpu_rbusy_reg  <= 1'b0;
            cpu_rdata_reg  <= '0;
`ifdef SPI_FLASH_PREFETCH_EN
            pend_valid_reg <= 1'b0;
            pend_addr_reg  <= '0;
`endif
        end else begin
            if (in_issue)
                cnt_reg <= '0;
            else if (in_wait_ack && !bus.flash_rbusy)
                cnt_reg <= cnt_reg + 1'b1;

            if (state_reg == IDLE) begin
                flush_seen_reg <= 1'b0;
                if (req_hit) begin
                    cpu_rdata_reg <= data_mem[req_idx];
                    cpu_rbusy_reg <= 1'b0;
                end else if (req_valid) begin
                    fetch_addr_reg <= req_addr;
                    cpu_rbusy_reg  <= 1'b1;
                end
`ifdef SPI_FLASH_PREFETCH_EN
                pend_valid_reg <= 1'b0;
`endif
            end else if (bus.flush) begin
                flush_seen_reg <= 1'b1;
            end

            if (state_reg == FILL) begin
                cpu_rdata_reg <= bus.flash_rdata;
                cpu_rbusy_reg <= 1'b0;
`ifdef SPI_FLASH_PREFETCH_EN
                // The prefetch starts with a clean flush history.
                flush_seen_reg <= 1'b0;
                if (!pf_present) fetch_addr_reg <= pf_addr;
`endif
            end

`ifdef SPI_FLASH_PREFETCH_EN
            if (in_prefetch && bus.cpu_rstrb && !pend_valid_reg) begin
                pend_valid_reg <= 1'b1;
                pend_addr_reg  <= bus.cpu_word_address;
                cpu_rbusy_reg  <= 1'b1;
            end
`endif
        end
    end

    // Line fill: tag and data written together when the fill is still wanted.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[fill_idx] <= bus.flash_rdata;
            tag_mem[fill_idx]  <= fill_tag;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_valid
            // Per-line valid bit: flush clears everything, a fill sets one.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    valid_reg[gi] <= 1'b0;
                else if (bus.flush)
                    valid_reg[gi] <= 1'b0;
                else if (fill_we && (fill_idx == IDX_W'(gi)))
                    valid_reg[gi] <= 1'b1;
            end
        end
    endgenerate
endmodule

// File: tb/tb_spi_flash_read_cache.sv
// Self-checking bench for spi_flash_read_cache: behavioural flash reader,
// line-level reference model of the cache contents, directed and random reads.
module tb_spi_flash_read_cache;
    localparam int LINES       = 16;
    localparam int ACK_TIMEOUT = 8;
    localparam int IDX_W       = 4;
    localparam int BOUND       = 2000;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    spi_flash_read_cache_if bus();

    spi_flash_read_cache #(.LINES(LINES), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Flash contents as seen through the reader.
    function automatic logic [31:0] flash_word(input logic [19:0] a);
        if (a == 20'h00010) return 32'hDEADBEEF;
        return ({12'h0, a} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Flash reader model: busy rises one cycle after it accepts a strobe,
    // stays high fm_busy cycles, data valid when busy falls.
    int          fm_busy = 40;
    int          fm_ignore_total = 0;
    int          fm_ignored = 0;
    int          fm_phase = 0;
    int          fm_left = 0;
    logic [19:0] fm_addr = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.flash_rbusy <= 1'b0;
            bus.flash_rdata <= '0;
            fm_phase        <= 0;
            fm_left         <= 0;
        end else begin
            case (fm_phase)
                0: if (bus.flash_rstrb === 1'b1) begin
                       if (fm_ignored < fm_ignore_total) fm_ignored <= fm_ignored + 1;
                       else begin
                           fm_addr  <= bus.flash_word_address;
                           fm_phase <= 1;
                       end
                   end
                1: begin
                       bus.flash_rbusy <= 1'b1;
                       fm_left         <= fm_busy;
                       fm_phase        <= 2;
                   end
                default: if (fm_left <= 1) begin
                       bus.flash_rbusy <= 1'b0;
                       bus.flash_rdata <= flash_word(fm_addr);
                       fm_phase        <= 0;
                   end else fm_left <= fm_left - 1;
            endcase
        end
    end

    // Strobe observer.
    int          cyc = 0;
    int          strobe_count = 0;
    int          last_strobe_cyc = 0;
    int          prev_strobe_cyc = 0;
    logic [19:0] last_strobe_addr = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.flash_rstrb === 1'b1) begin
            strobe_count     <= strobe_count + 1;
            prev_strobe_cyc  <= last_strobe_cyc;
            last_strobe_cyc  <= cyc;
            last_strobe_addr <= bus.flash_word_address;
        end
    end

    // Reference model: which word address each line currently holds.
    bit          ref_valid [LINES];
    logic [19:0] ref_addr  [LINES];

    function automatic bit ref_hit(input logic [19:0] a);
        int idx;
        idx = int'(a[IDX_W-1:0]);
        return ref_valid[idx] && (ref_addr[idx] == a);
    endfunction

    task automatic ref_clear();
        for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
    endtask

    task automatic ref_fill(input logic [19:0] a);
        ref_valid[int'(a[IDX_W-1:0])] = 1'b1;
        ref_addr[int'(a[IDX_W-1:0])]  = a;
    endtask

    task automatic pulse_flush();
        @(negedge clk); bus.flush = 1'b1;
        @(negedge clk); bus.flush = 1'b0;
        ref_clear();
    endtask

    // One CPU read: returns expected hit, observed hit/data, busy cycles and
    // the number of flash strobes issued for it. flush_at > 0 pulses flush
    // on that busy cycle.
    task automatic do_read(input logic [19:0] a, input bit with_flush, input int flush_at,
                           output bit exp_hit, output bit got_hit,
                           output logic [31:0] got_data, output int busy_n, output int nstr);
        int s0;
        if (with_flush) ref_clear();
        exp_hit = ref_hit(a);
        s0 = strobe_count;
        @(negedge clk);
        bus.cpu_rstrb = 1'b1; bus.cpu_word_address = a; bus.flush = with_flush;
        @(negedge clk);
        bus.cpu_rstrb = 1'b0; bus.flush = 1'b0;
        busy_n = 0;
        while (bus.cpu_rbusy === 1'b1 && busy_n < BOUND) begin
            busy_n++;
            bus.flush = (busy_n == flush_at);
            @(negedge clk);
        end
        bus.flush = 1'b0;
        checks++;
        if (busy_n >= BOUND) begin
            errors++;
            $display("FAIL read_bound addr=%h: cpu_rbusy still high after %0d cycles, required to fall", a, busy_n);
        end
        got_hit  = (busy_n == 0);
        got_data = bus.cpu_rdata;
        nstr     = strobe_count - s0;
        if (!exp_hit) begin
            if (flush_at > 0) ref_clear();
            else ref_fill(a);
`ifdef SPI_FLASH_PREFETCH_EN
            ref_fill(a + 20'd1);
            repeat (fm_busy + 2 * ACK_TIMEOUT + 12) @(negedge clk);
`endif
        end
        $display("read addr=%h hit=%0b data=%h busy=%0d strobes=%0d", a, got_hit, got_data, busy_n, nstr);
    endtask

    bit          eh, gh;
    logic [31:0] gd;
    int          bn, ns;

    task automatic test_reset();
        bus.cpu_rstrb = 1'b0; bus.cpu_word_address = '0; bus.flush = 1'b0;
        reset = 1'b0;
        ref_clear();
        repeat (3) @(negedge clk);
        checks++; if (bus.cpu_rbusy !== 1'b0) begin errors++; $display("FAIL reset_rbusy got=%b exp=0", bus.cpu_rbusy); end
        checks++; if (bus.flash_rstrb !== 1'b0) begin errors++; $display("FAIL reset_rstrb got=%b exp=0", bus.flash_rstrb); end
        checks++; if (bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.cpu_rdata); end
        checks++; if (bus.flash_word_address !== 20'h0) begin errors++; $display("FAIL reset_faddr got=%h exp=0", bus.flash_word_address); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cold_miss();
        fm_busy = 40;
        do_read(20'h00010, 1'b0, -1, eh, gh, gd, bn, ns);
        checks++; if (gh !== 1'b0) begin errors++; $display("FAIL cold_hit got=%b exp=0", gh); end
        checks++; if (ns != 1) begin errors++; $display("FAIL cold_strobes got=%0d exp=1", ns); end
        checks++; if (last_strobe_addr !== 20'h00010) begin errors++; $display("FAIL cold_faddr got=%h exp=00010", last_strobe_addr); end
        checks++; if (bn != 44) begin errors++; $display("FAIL cold_busy got=%0d exp=44", bn); end
        checks++; if (gd !== 32'hDEADBEEF) begin errors++; $display("FAIL cold_data got=%h exp=deadbeef", gd); end
    endtask

    task automatic test_hit();
        do_read(20'h00010, 1'b0, -1, eh, gh, gd, bn, ns);
        checks++; if (gh !== 1'b1) begin errors++; $display("FAIL hit_hit got=%b exp=1", gh); end
        checks++; if (ns != 0) begin errors++; $display("FAIL hit_strobes got=%0d exp=0", ns); end
        checks++; if (gd !== 32'hDEADBEEF) begin errors++; $display("FAIL hit_data got=%h exp=deadbeef", gd); end
    endtask

    task automatic test_conflict_flush();
        logic [19:0] seq [5];
        int misses;
        seq = '{20'h00010, 20'h00020, 20'h00010, 20'h00010, 20'h00010};
        fm_busy = 6;
        misses = 0;
        pulse_flush();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) pulse_flush();
            do_read(seq[i], 1'b0, -1, eh, gh, gd, bn, ns);
            if (!gh) misses++;
            checks++; if (gh !== eh) begin errors++; $display("FAIL conflict_hit[%0d] got=%b exp=%b", i, gh, eh); end
            checks++; if (gd !== flash_word(seq[i])) begin errors++; $display("FAIL conflict_data[%0d] got=%h exp=%h", i, gd, flash_word(seq[i])); end
        end
        checks++; if (misses != 4) begin errors++; $display("FAIL conflict_misses got=%0d exp=4", misses); end
    endtask

    task automatic test_timeout();
        fm_busy = 5;
        fm_ignore_total++;
        do_read(20'h04567, 1'b0, -1, eh, gh, gd, bn, ns);
        checks++; if (ns != 2) begin errors++; $display("FAIL timeout_strobes got=%0d exp=2", ns); end
        checks++; if (last_strobe_cyc - prev_strobe_cyc != ACK_TIMEOUT + 1) begin
            errors++; $display("FAIL timeout_gap got=%0d exp=%0d", last_strobe_cyc - prev_strobe_cyc, ACK_TIMEOUT + 1); end
        checks++; if (bn != 5 + 4 + ACK_TIMEOUT + 1) begin errors++; $display("FAIL timeout_busy got=%0d exp=%0d", bn, 5 + 4 + ACK_TIMEOUT + 1); end
        checks++; if (gd !== flash_word(20'h04567)) begin errors++; $display("FAIL timeout_data got=%h exp=%h", gd, flash_word(20'h04567)); end
    endtask

    task automatic test_flush_inflight();
        fm_busy = 20;
        do_read(20'h05678, 1'b0, 10, eh, gh, gd, bn, ns);
        checks++; if (gd !== flash_word(20'h05678)) begin errors++; $display("FAIL inflight_data got=%h exp=%h", gd, flash_word(20'h05678)); end
        do_read(20'h05678, 1'b0, -1, eh, gh, gd, bn, ns);
        checks++; if (gh !== 1'b0) begin errors++; $display("FAIL inflight_revalidated got=%b exp=0", gh); end
    endtask

    task automatic test_flush_with_strobe();
        fm_busy = 4;
        do_read(20'h00777, 1'b0, -1, eh, gh, gd, bn, ns);
        do_read(20'h00777, 1'b0, -1, eh, gh, gd, bn, ns);
        checks++; if (gh !== 1'b1) begin errors++; $display("FAIL fws_prehit got=%b exp=1", gh); end
        do_read(20'h00777, 1'b1, -1, eh, gh, gd, bn, ns);
        checks++; if (gh !== 1'b0 || ns != 1) begin errors++; $display("FAIL fws_miss got hit=%b strobes=%0d exp hit=0 strobes=1", gh, ns); end
        do_read(20'h00777, 1'b0, -1, eh, gh, gd, bn, ns);
        checks++; if (gh !== 1'b1) begin errors++; $display("FAIL fws_posthit got=%b exp=1", gh); end
    endtask

    task automatic test_random();
        logic [19:0] a;
        bit          wf, ign, miss;
        int          exp_ns;
        for (int i = 0; i < 40; i++) begin
            a   = (20'h01230 * 20'($urandom_range(0, 2))) | 20'($urandom_range(0, 15));
            wf  = ($urandom_range(0, 7) == 0);
            fm_busy = $urandom_range(1, 10);
            miss = wf || !ref_hit(a);
            ign  = miss && ($urandom_range(0, 5) == 0);
            if (ign) fm_ignore_total++;
            exp_ns = miss ? (ign ? 2 : 1) : 0;
            do_read(a, wf, -1, eh, gh, gd, bn, ns);
            checks++; if (gh !== eh) begin errors++; $display("FAIL rand_hit[%0d] addr=%h got=%b exp=%b", i, a, gh, eh); end
            checks++; if (gd !== flash_word(a)) begin errors++; $display("FAIL rand_data[%0d] addr=%h got=%h exp=%h", i, a, gd, flash_word(a)); end
            checks++; if (ns != exp_ns) begin errors++; $display("FAIL rand_strobes[%0d] got=%0d exp=%0d", i, ns, exp_ns); end
        end
    endtask

    task automatic test_reset_midflight();
        fm_busy = 30;
        pulse_flush();
        @(negedge clk); bus.cpu_rstrb = 1'b1; bus.cpu_word_address = 20'h09999;
        @(negedge clk); bus.cpu_rstrb = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (bus.cpu_rbusy !== 1'b1) begin errors++; $display("FAIL midreset_pre_busy got=%b exp=1", bus.cpu_rbusy); end
        reset = 1'b0;
        #1;
        checks++; if (bus.cpu_rbusy !== 1'b0) begin errors++; $display("FAIL midreset_rbusy got=%b exp=0", bus.cpu_rbusy); end
        checks++; if (bus.flash_rstrb !== 1'b0) begin errors++; $display("FAIL midreset_rstrb got=%b exp=0", bus.flash_rstrb); end
        checks++; if (bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL midreset_rdata got=%h exp=0", bus.cpu_rdata); end
        checks++; if (bus.flash_word_address !== 20'h0) begin errors++; $display("FAIL midreset_faddr got=%h exp=0", bus.flash_word_address); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ref_clear();
        fm_busy = 3;
        do_read(20'h00010, 1'b0, -1, eh, gh, gd, bn, ns);
        checks++; if (gh !== 1'b0) begin errors++; $display("FAIL postreset_hit got=%b exp=0", gh); end
        checks++; if (gd !== 32'hDEADBEEF) begin errors++; $display("FAIL postreset_data got=%h exp=deadbeef", gd); end
    endtask

`ifdef SPI_FLASH_PREFETCH_EN
    task automatic test_prefetch();
        fm_busy = 8;
        pulse_flush();
        do_read(20'hFFFFF, 1'b0, -1, eh, gh, gd, bn, ns);
        checks++; if (last_strobe_addr !== 20'h00000) begin errors++; $display("FAIL pf_addr got=%h exp=00000", last_strobe_addr); end
        do_read(20'h00000, 1'b0, -1, eh, gh, gd, bn, ns);
        checks++; if (gh !== 1'b1 || ns != 0) begin errors++; $display("FAIL pf_hit got hit=%b strobes=%0d exp hit=1 strobes=0", gh, ns); end
        checks++; if (gd !== flash_word(20'h00000)) begin errors++; $display("FAIL pf_data got=%h exp=%h", gd, flash_word(20'h00000)); end
    endtask
`endif

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict_flush();
        test_timeout();
        test_flush_inflight();
        test_flush_with_strobe();
        test_random();
        test_reset_midflight();
`ifdef SPI_FLASH_PREFETCH_EN
        test_prefetch();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/spi_flash_read_cache.md
Name: spi_flash_read_cache

Overview:
- Direct-mapped read cache that sits between the CPU load path and the memory-mapped SPI flash word reader.
- Converts CPU word-read strobes into single-word flash read strobes on a miss.
- Serves repeated reads from local registers with one-cycle latency on a hit.
- Hides the roughly 70-cycle SPI transaction for loops and constant tables executing from flash.

Parameters:
- LINES, 16, number of one-word cache lines; power of 2, 2..256; IDX_W = log2(LINES).
- ACK_TIMEOUT, 8, cycles to wait for flash_rbusy to rise after flash_rstrb before re-issuing the strobe.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_rstrb  in  1  one-cycle read request.
- cpu_word_address  in  20  word address of the request.
- cpu_rdata  out  32  read data; held until the next completed request.
- cpu_rbusy  out  1  high while a request is being serviced from flash.
- flush  in  1  invalidate all lines.
- flash_rstrb  out  1  one-cycle read strobe to the flash reader.
- flash_word_address  out  20  word address to the flash reader.
- flash_rdata  in  32  data from the flash reader, already byte-swizzled.
- flash_rbusy  in  1  flash reader busy; rises the cycle after strobe acceptance.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; all valid bits=0.
  - cpu_rdata=0, cpu_rbusy=0, flash_rstrb=0, flash_word_address=0.
  - Timeout counter=0.
  - Tag/data arrays are not reset.
- Address split: index=addr[IDX_W-1:0], tag=addr[19:IDX_W].
- IDLE:
  - Hit (cpu_rstrb=1, line valid, tag match, flush=0): cpu_rdata<=line data at the next edge; cpu_rbusy stays 0. Latency 1 cycle.
  - Miss: latch the address; cpu_rbusy<=1; go to ISSUE.
  - flush and cpu_rstrb in the same cycle: flush applies first, and the request is a miss.
- ISSUE: flash_rstrb=1 for exactly one cycle with flash_word_address=latched address; clear timeout counter; go to WAIT_ACK.
- WAIT_ACK:
  - flash_rbusy=1 -> WAIT_DATA.
  - Otherwise the counter increments; at ACK_TIMEOUT -> ISSUE (re-strobe). Retries are unlimited; this covers the reader's one-cycle post-reset START state.
- WAIT_DATA: flash_rbusy=0 -> FILL.
- FILL:
  - Write data/tag into the line and set valid, unless a flush arrived during this miss.
  - cpu_rdata<=flash_rdata; cpu_rbusy<=0; go to IDLE.
- Miss latency: cpu_rbusy is high from the cycle after the strobe until FILL completes. Total is 4 cycles plus the flash busy time.
- cpu_rstrb while cpu_rbusy=1: ignored; it is a protocol violation.
- flush in any state: all valid bits clear at the next edge. An in-flight miss still returns data to the CPU, but does not validate its line.
- flash_word_address holds its last value outside ISSUE.
- Reset mid-transaction: everything returns to reset values immediately. The flash reader must be reset by the same signal.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DATA, FILL, plus the optional PF_ISSUE, PF_WAIT_ACK, PF_WAIT_DATA, PF_FILL.

Optional Feature:
- Macro: SPI_FLASH_PREFETCH_EN.
- Defined: after each demand FILL, if line(addr+1) is invalid or its tag mismatches, fetch addr+1 through the PF_* states. PF_* states use identical handshake and timeout rules, and PF_FILL writes the line only.
  - Address wraps: 0xFFFFF+1 -> 0x00000.
  - cpu_rstrb during prefetch is captured into a pending register. cpu_rbusy<=1 the next cycle. After PF_FILL the pending request is looked up; a hit completes in 1 further cycle with cpu_rbusy falling.
  - flush during prefetch aborts validation of the prefetched line.
- Undefined: FILL returns directly to IDLE and the PF_* states do not exist.

Test Plan:
- Reset: assert reset=0 mid-simulation -> cpu_rbusy=0, flash_rstrb=0, cpu_rdata=0. The first read after release is a miss.
- Cold miss: strobe 0x00010, flash model returns 0xDEADBEEF after 40 busy cycles -> exactly one flash_rstrb with address 0x00010; cpu_rbusy high 44 cycles; cpu_rdata=0xDEADBEEF.
- Hit: re-read 0x00010 -> no flash_rstrb; cpu_rdata=0xDEADBEEF one cycle later; cpu_rbusy stays 0.
- Conflict/flush (LINES=16): read 0x00010, 0x00020, 0x00010 -> three misses. Then read 0x00010 (hit), pulse flush, read 0x00010 -> miss.
- Ack timeout: model ignores the first strobe -> second flash_rstrb exactly ACK_TIMEOUT+1 cycles after the first; data returned correctly.
- Prefetch (macro on): miss at 0xFFFFF -> demand fetch, then prefetch of 0x00000. The next read of 0x00000 hits with no flash_rstrb.
